// File: rtl/alu_core.sv
// alu_core: registered 8-bit ALU. Sixteen opcodes produce a 16-bit result,
// a carry/borrow flag and a zero flag, one cycle after the operands are sampled.
module alu_core (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  opcode,
  input  logic [7:0]  opd_1,
  input  logic [7:0]  opd_2,
  output logic [15:0] res,
  output logic        c_flag,
  output logic        z_flag
);

  localparam int DATA_W = 8;

  // Evaluate one operation; returns {carry, result}.
  function automatic logic [2*DATA_W:0] alu_eval(
    input logic [3:0]        op,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic [DATA_W:0]     wide;
    logic [2*DATA_W-1:0] prod;
    logic [2*DATA_W-1:0] r;
    logic                c;
    begin
      wide = '0;
      prod = '0;
      r    = '0;
      c    = 1'b0;
      case (op)
        4'h0: begin
          wide = {1'b0, a} + {1'b0, b};
          r[DATA_W-1:0] = wide[DATA_W-1:0];
          c = wide[DATA_W];
        end
        4'h1: begin
          wide = {1'b0, a} - {1'b0, b};
          r[DATA_W-1:0] = wide[DATA_W-1:0];
          c = wide[DATA_W];
        end
        4'h2: begin
          prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
          r = prod;
          c = |prod[2*DATA_W-1:DATA_W];
        end
        4'h3: begin
          // Divide by zero is flagged with an all-ones result and carry set.
          if (b == '0) begin
            r = '1;
            c = 1'b1;
          end else begin
            r = {a % b, a / b};
          end
        end
        4'h4: r[DATA_W-1:0] = a & b;
        4'h5: r[DATA_W-1:0] = a | b;
        4'h6: r[DATA_W-1:0] = a ^ b;
        4'h7: r[DATA_W-1:0] = ~a;
        4'h8: begin
          r[DATA_W-1:0] = {a[DATA_W-2:0], 1'b0};
          c = a[DATA_W-1];
        end
        4'h9: begin
          r[DATA_W-1:0] = {1'b0, a[DATA_W-1:1]};
          c = a[0];
        end
        4'hA: begin
          r[DATA_W-1:0] = {a[DATA_W-2:0], a[DATA_W-1]};
          c = a[DATA_W-1];
        end
        4'hB: begin
          r[DATA_W-1:0] = {a[0], a[DATA_W-1:1]};
          c = a[0];
        end
        4'hC: begin
          wide = {1'b0, a} + {{DATA_W{1'b0}}, 1'b1};
          r[DATA_W-1:0] = wide[DATA_W-1:0];
          c = wide[DATA_W];
        end
        4'hD: begin
          wide = {1'b0, a} - {{DATA_W{1'b0}}, 1'b1};
          r[DATA_W-1:0] = wide[DATA_W-1:0];
          c = wide[DATA_W];
        end
        4'hE: begin
          r[0] = (a > b);
          r[1] = (a == b);
          r[2] = (a < b);
        end
        default: r = {a, b};
      endcase
      alu_eval = {c, r};
    end
  endfunction

  logic [2*DATA_W:0]   eval_p0;
  logic [2*DATA_W-1:0] res_p1;
  logic                c_p1;
  logic                z_p1;

  // Stage p0: combinational evaluation of the sampled-next operands.
  always_comb begin
    eval_p0 = alu_eval(opcode, opd_1, opd_2);
  end

  // Stage p1: register result and flags; reset forces the zero result.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_p1 <= '0;
      c_p1   <= 1'b0;
      z_p1   <= 1'b1;
    end else begin
      res_p1 <= eval_p0[2*DATA_W-1:0];
      c_p1   <= eval_p0[2*DATA_W];
      z_p1   <= (eval_p0[2*DATA_W-1:0] == '0);
    end
  end

  assign res    = res_p1;
  assign c_flag = c_p1;
  assign z_flag = z_p1;

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: directed vectors for alu_core; a driver pushes expected
// responses into a queue and an independent monitor pops and compares them.
module tb_alu_core;

  logic        clk;
  logic        rst;
  logic [3:0]  opcode;
  logic [7:0]  opd_1;
  logic [7:0]  opd_2;
  logic [15:0] res;
  logic        c_flag;
  logic        z_flag;

  int errors = 0;
  int checks = 0;

  logic [17:0] exp_q[$];
  string       name_q[$];
  logic        drive_done = 1'b0;

  alu_core dut (
    .clk    (clk),
    .rst    (rst),
    .opcode (opcode),
    .opd_1  (opd_1),
    .opd_2  (opd_2),
    .res    (res),
    .c_flag (c_flag),
    .z_flag (z_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue the response expected after the next edge.
  task automatic apply(input logic r, input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [15:0] er, input logic ec,
                       input logic ez, input string nm);
    @(negedge clk);
    rst    = r;
    opcode = op;
    opd_1  = a;
    opd_2  = b;
    exp_q.push_back({er, ec, ez});
    name_q.push_back(nm);
  endtask

  // Monitor: one response per edge, sampled shortly after the edge.
  always @(posedge clk) begin
    logic [17:0] e;
    string       n;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks = checks + 1;
      if ({res, c_flag, z_flag} !== e) begin
        errors = errors + 1;
        $display("FAIL %s: got res=%h c=%b z=%b, expected res=%h c=%b z=%b",
                 n, res, c_flag, z_flag, e[17:2], e[1], e[0]);
      end
    end
  end

  initial begin
    rst = 1'b1; opcode = 4'h0; opd_1 = 8'h00; opd_2 = 8'h00;

    // Reset held for two edges, then release.
    apply(1, 4'h0, 8'hAA, 8'h55, 16'h0000, 0, 1, "reset0");
    apply(1, 4'h0, 8'hAA, 8'h55, 16'h0000, 0, 1, "reset1");
    apply(0, 4'h0, 8'hAA, 8'h55, 16'h00FF, 0, 0, "release_add");

    // Opcode sweep with A=AA, B=55.
    apply(0, 4'h0, 8'hAA, 8'h55, 16'h00FF, 0, 0, "ADD");
    apply(0, 4'h1, 8'hAA, 8'h55, 16'h0055, 0, 0, "SUB");
    apply(0, 4'h2, 8'hAA, 8'h55, 16'h3872, 1, 0, "MUL");
    apply(0, 4'h3, 8'hAA, 8'h55, 16'h0002, 0, 0, "DIV");
    apply(0, 4'h4, 8'hAA, 8'h55, 16'h0000, 0, 1, "AND");
    apply(0, 4'h5, 8'hAA, 8'h55, 16'h00FF, 0, 0, "OR");
    apply(0, 4'h6, 8'hAA, 8'h55, 16'h00FF, 0, 0, "XOR");
    apply(0, 4'h7, 8'hAA, 8'h55, 16'h0055, 0, 0, "NOT");
    apply(0, 4'h8, 8'hAA, 8'h55, 16'h0054, 1, 0, "SHL");
    apply(0, 4'h9, 8'hAA, 8'h55, 16'h0055, 0, 0, "SHR");
    apply(0, 4'hA, 8'hAA, 8'h55, 16'h0055, 1, 0, "ROL");
    apply(0, 4'hB, 8'hAA, 8'h55, 16'h0055, 0, 0, "ROR");
    apply(0, 4'hC, 8'hAA, 8'h55, 16'h00AB, 0, 0, "INC");
    apply(0, 4'hD, 8'hAA, 8'h55, 16'h00A9, 0, 0, "DEC");
    apply(0, 4'hE, 8'hAA, 8'h55, 16'h0001, 0, 0, "CMP");
    apply(0, 4'hF, 8'hAA, 8'h55, 16'hAA55, 0, 0, "CAT");

    // Boundaries.
    apply(0, 4'h0, 8'hFF, 8'h01, 16'h0000, 1, 1, "ADD_wrap");
    apply(0, 4'h1, 8'h00, 8'h01, 16'h00FF, 1, 0, "SUB_borrow");
    apply(0, 4'hC, 8'hFF, 8'h00, 16'h0000, 1, 1, "INC_wrap");
    apply(0, 4'hD, 8'h00, 8'h00, 16'h00FF, 1, 0, "DEC_wrap");
    apply(0, 4'h2, 8'hFF, 8'hFF, 16'hFE01, 1, 0, "MUL_max");
    apply(0, 4'h8, 8'h01, 8'h00, 16'h0002, 0, 0, "SHL_nocarry");
    apply(0, 4'h9, 8'h01, 8'h00, 16'h0000, 1, 1, "SHR_carry");

    // Division.
    apply(0, 4'h3, 8'h07, 8'h00, 16'hFFFF, 1, 0, "DIV_by0");
    apply(0, 4'h3, 8'h07, 8'h02, 16'h0103, 0, 0, "DIV_rem");
    apply(0, 4'h3, 8'h00, 8'h05, 16'h0000, 0, 1, "DIV_zero");

    // Compare and concatenate.
    apply(0, 4'hE, 8'h10, 8'h10, 16'h0002, 0, 0, "CMP_eq");
    apply(0, 4'hE, 8'h01, 8'h02, 16'h0004, 0, 0, "CMP_lt");
    apply(0, 4'hF, 8'h00, 8'h00, 16'h0000, 0, 1, "CAT_zero");
    apply(0, 4'hF, 8'h12, 8'h34, 16'h1234, 0, 0, "CAT_order");

    // Mid-stream reset discards the operation that follows the MUL.
    apply(0, 4'h2, 8'h10, 8'h10, 16'h0100, 1, 0, "MUL_pre_rst");
    apply(1, 4'h2, 8'hFF, 8'hFF, 16'h0000, 0, 1, "mid_rst");
    apply(0, 4'h1, 8'h09, 8'h04, 16'h0005, 0, 0, "SUB_post_rst");

    // Drain: every queued response must have been seen within a few edges.
    for (int i = 0; i < 4; i++) @(negedge clk);
    drive_done = 1'b1;
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain: got %0d pending responses, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_core.md
Name: alu_core

Overview:
- Registered 8-bit combinational-style ALU with 16 opcodes, a 16-bit result, a carry/borrow flag and a zero flag.
- Operands and opcode are sampled on every rising clock edge. The result and flags appear one cycle later.
- Used as the datapath execution unit under an external controller FSM that drives opcode and operands.

Parameters:
- None. Widths are fixed: operands 8 bits, opcode 4 bits, result 16 bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- opcode  input  4  operation select, decoded below
- opd_1  input  8  operand A, unsigned
- opd_2  input  8  operand B, unsigned
- res  output  16  registered result
- c_flag  output  1  registered carry/borrow/overflow flag
- z_flag  output  1  registered zero flag

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset:
  - When rst=1 at a rising edge: res=16'h0000, c_flag=0, z_flag=1.
  - Reset has priority over computation.
  - Asserting reset mid-stream discards the pending operation.
- Latency: 1 cycle.
  - Inputs present at edge N define res/c_flag/z_flag after edge N.
  - A new operation is accepted every cycle; there is no handshake and no enable.
  - Outputs hold between edges.
- All arithmetic is unsigned. Unless stated otherwise, res[15:8]=8'h00 and c_flag=0.
- Opcode map (A=opd_1, B=opd_2):
  - 0 ADD: res[7:0]=A+B (mod 256); c_flag = carry out of bit 7.
  - 1 SUB: res[7:0]=A-B (mod 256); c_flag=1 iff A<B (borrow).
  - 2 MUL: res=A*B as a full 16-bit product; c_flag=1 iff res[15:8]!=0.
  - 3 DIV: res[7:0]=A/B, res[15:8]=A%B.
    - B=0: res=16'hFFFF, c_flag=1 (divide-by-zero indicator).
  - 4 AND: res[7:0]=A&B.
  - 5 OR: res[7:0]=A|B.
  - 6 XOR: res[7:0]=A^B.
  - 7 NOT: res[7:0]=~A. B is ignored.
  - 8 SHL: res[7:0]=A<<1 with zero fill; c_flag=A[7].
  - 9 SHR: res[7:0]=A>>1 (logical); c_flag=A[0].
  - A ROL: res[7:0]={A[6:0],A[7]}; c_flag=A[7].
  - B ROR: res[7:0]={A[0],A[7:1]}; c_flag=A[0].
  - C INC: res[7:0]=A+1; c_flag=1 iff A=8'hFF (wraps to 00).
  - D DEC: res[7:0]=A-1; c_flag=1 iff A=8'h00 (wraps to FF).
  - E CMP: res[0]=(A>B), res[1]=(A==B), res[2]=(A<B), res[15:3]=0. Exactly one of bits 0-2 is set.
  - F CAT: res={A,B}.
- z_flag=1 iff the 16-bit res being registered equals 0, for every opcode (including the DIV-by-zero and CMP results).
- There are no undefined opcodes: all 16 codes are decoded.
- X/Z on inputs is not handled specially.

Test Plan:
- Reset: hold rst=1 for 2 edges with A=AA, B=55, op=0 -> res=0000, c=0, z=1. Release rst -> next edge res=00FF.
- Sweep all opcodes 0..F with A=AA, B=55, one per cycle. Check each result 1 cycle after it is applied:
  - ADD 00FF c0
  - SUB 0055 c0
  - MUL 3872 c1
  - DIV 0002 c0
  - AND 0000 z1
  - OR 00FF
  - XOR 00FF
  - NOT 0055
  - SHL 0054 c1
  - SHR 0055 c0
  - ROL 0055 c1
  - ROR 0055 c0
  - INC 00AB
  - DEC 00A9
  - CMP 0001
  - CAT AA55
  - z=0 everywhere except AND.
- Boundaries:
  - A=FF, B=01 ADD -> 0000 c1 z1.
  - A=00, B=01 SUB -> 00FF c1.
  - A=FF INC -> 0000 c1 z1.
  - A=00 DEC -> 00FF c1.
  - A=FF, B=FF MUL -> FE01 c1.
- DIV cases:
  - A=07, B=00 -> FFFF c1 z0.
  - A=07, B=02 -> 0103 c0.
  - A=00, B=05 -> 0000 z1.
- CMP cases:
  - A=10, B=10 -> 0002.
  - A=01, B=02 -> 0004.
  - A=00, B=00 CAT -> 0000 z1.
- Mid-stream reset: issue MUL at edge N, assert rst at edge N+1 -> outputs 0000/c0/z1 after N+1. Next operation is computed normally after deassertion.
